led_pattern_sequencer: RTL and testbench

//   Sequences the colorful-LED board's RGB outputs. Replaces per-pattern derived

---
 rtl/led_pattern_sequencer.sv | 139 +++++++++++++
 tb/tb_led_pattern_sequencer.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/led_pattern_sequencer.sv
// RGB LED pattern sequencer (OFF/BLINK/CYCLE/BREATHE) driven by prescaler enable ticks in the clk_in domain.
// LED outputs are registered one cycle after the state that produces them; there is no backpressure, mode_btn is always accepted.
module led_pattern_sequencer #(
    parameter int TICK_DIV    = 12000000,
    parameter int BREATHE_DIV = 46875,
    parameter int PWM_BITS    = 8
) (
    input  logic       clk_in,
    input  logic       rst_n,
    input  logic       mode_btn,
    input  logic       pause,
    output logic [1:0] mode,
    output logic       tick,
    output logic       led_r,
    output logic       led_g,
    output logic       led_b
);
    localparam int TW = $clog2(TICK_DIV);
    localparam int BW = $clog2(BREATHE_DIV);
    localparam logic [TW-1:0]       T_LAST = TW'(TICK_DIV - 1);
    localparam logic [BW-1:0]       B_LAST = BW'(BREATHE_DIV - 1);
    localparam logic [PWM_BITS-1:0] FULL   = '1;

    typedef enum logic [1:0] {
        M_OFF     = 2'd0,
        M_BLINK   = 2'd1,
        M_CYCLE   = 2'd2,
        M_BREATHE = 2'd3
    } mode_e;

    mode_e               mode_q, mode_d;
    logic [TW-1:0]       tcnt_q, tcnt_d;
    logic [BW-1:0]       bcnt_q, bcnt_d;
    logic                phase_q, phase_d;
    logic [2:0]          cidx_q, cidx_d;
    logic [PWM_BITS-1:0] duty_q, duty_d;
    logic                dir_q, dir_d;
    logic [PWM_BITS-1:0] pwm_q, pwm_d;
    logic [2:0]          led_q, led_d;
    logic                tick_w, btick_w;
    logic [2:0]          cidx_inc;

    function automatic logic [2:0] color_of(input logic [2:0] idx);
        case (idx)
            3'd0:    color_of = 3'b100;
            3'd1:    color_of = 3'b010;
            3'd2:    color_of = 3'b001;
            3'd3:    color_of = 3'b110;
            3'd4:    color_of = 3'b011;
            3'd5:    color_of = 3'b101;
            3'd6:    color_of = 3'b111;
            default: color_of = 3'b000;
        endcase
    endfunction

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            mode_q  <= M_OFF;
            tcnt_q  <= '0;
            bcnt_q  <= '0;
            phase_q <= 1'b0;
            cidx_q  <= '0;
            duty_q  <= '0;
            dir_q   <= 1'b0;
            pwm_q   <= '0;
            led_q   <= '0;
        end else begin
            mode_q  <= mode_d;
            tcnt_q  <= tcnt_d;
            bcnt_q  <= bcnt_d;
            phase_q <= phase_d;
            cidx_q  <= cidx_d;
            duty_q  <= duty_d;
            dir_q   <= dir_d;
            pwm_q   <= pwm_d;
            led_q   <= led_d;
        end
    end

    always_comb begin
        mode_d   = mode_q;
        tcnt_d   = tcnt_q;
        bcnt_d   = bcnt_q;
        phase_d  = phase_q;
        cidx_d   = cidx_q;
        duty_d   = duty_q;
        dir_d    = dir_q;
        pwm_d    = pwm_q + 1'b1;
        led_d    = 3'b000;
        tick_w   = (tcnt_q == T_LAST) && !pause;
        btick_w  = (bcnt_q == B_LAST) && !pause;
        cidx_inc = (cidx_q == 3'd6) ? 3'd0 : cidx_q + 3'd1;

        case (mode_q)
            M_BLINK:   led_d = {3{phase_q}};
            M_CYCLE:   led_d = color_of(cidx_q);
            M_BREATHE: led_d = color_of(cidx_q) & {3{pwm_q < duty_q}};
            default:   led_d = 3'b000;
        endcase

        // A button press restarts the new mode from scratch and swallows any same-cycle step.
        if (mode_btn) begin
            mode_d  = mode_e'(mode_q + 2'd1);
            tcnt_d  = '0;
            bcnt_d  = '0;
            phase_d = 1'b0;
            cidx_d  = '0;
            duty_d  = '0;
            dir_d   = 1'b0;
        end else if (!pause) begin
            tcnt_d = tick_w  ? '0 : tcnt_q + 1'b1;
            bcnt_d = btick_w ? '0 : bcnt_q + 1'b1;
            case (mode_q)
                M_BLINK: if (tick_w) phase_d = ~phase_q;
                M_CYCLE: if (tick_w) cidx_d = cidx_inc;
                M_BREATHE: begin
                    if (btick_w) begin
                        if (!dir_q) begin
                            if (duty_q == FULL) dir_d  = 1'b1;
                            else                duty_d = duty_q + 1'b1;
                        end else if (duty_q == '0) begin
                            dir_d = 1'b0;
                        end else begin
                            duty_d = duty_q - 1'b1;
                            if (duty_q == PWM_BITS'(1)) cidx_d = cidx_inc;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign mode  = mode_q;
    assign tick  = tick_w;
    assign led_r = led_q[2];
    assign led_g = led_q[1];
    assign led_b = led_q[0];
endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Randomized bench for led_pattern_sequencer against an arithmetic model built from tick/step counts.
module tb_led_pattern_sequencer;
    localparam int TD = 4;
    localparam int BD = 2;
    localparam int PB = 3;
    localparam int FS = (1 << PB) - 1;

    logic       clk_in = 1'b0;
    logic       rst_n  = 1'b0;
    logic       mode_btn = 1'b0;
    logic       pause = 1'b0;
    logic [1:0] mode;
    logic       tick;
    logic       led_r, led_g, led_b;

    led_pattern_sequencer #(.TICK_DIV(TD), .BREATHE_DIV(BD), .PWM_BITS(PB)) dut (
        .clk_in(clk_in), .rst_n(rst_n), .mode_btn(mode_btn), .pause(pause),
        .mode(mode), .tick(tick), .led_r(led_r), .led_g(led_g), .led_b(led_b)
    );

    always #5 clk_in = ~clk_in;

    int errors = 0;
    int checks = 0;

    // Model: counts of elapsed unpaused cycles, ticks and breathe steps since mode entry
    int m_mode, n_t, n_b, ticks, bsteps, pwm;
    logic [2:0] led_exp;
    logic [2:0] colors [7] = '{3'b100, 3'b010, 3'b001, 3'b110, 3'b011, 3'b101, 3'b111};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int duty_of(input int s);
        int m;
        m = s % 16;
        if (m == 0) return 0;
        if (m <= FS) return m;
        if (m == FS + 1) return FS;
        return 15 - m;
    endfunction

    task automatic model_reset();
        m_mode = 0; n_t = 0; n_b = 0; ticks = 0; bsteps = 0; pwm = 0; led_exp = 3'b000;
    endtask

    // One clock cycle: drive inputs at the negedge, check, advance the model, wait for the next negedge.
    task automatic step(input logic b, input logic p);
        logic tk, btk;
        logic [2:0] nxt;
        mode_btn = b;
        pause    = p;
        #1;
        tk  = !p && (n_t % TD == TD - 1);
        btk = !p && (n_b % BD == BD - 1);
        chk("mode", 32'(mode), 32'(m_mode));
        chk("tick", 32'(tick), 32'(tk));
        chk("leds", 32'({led_r, led_g, led_b}), 32'(led_exp));
        case (m_mode)
            1: nxt = (ticks % 2 == 1) ? 3'b111 : 3'b000;
            2: nxt = colors[ticks % 7];
            3: nxt = ((pwm % (FS + 1)) < duty_of(bsteps)) ? colors[((bsteps + 1) / 16) % 7] : 3'b000;
            default: nxt = 3'b000;
        endcase
        if (b) begin
            m_mode = (m_mode + 1) % 4;
            n_t = 0; n_b = 0; ticks = 0; bsteps = 0;
        end else if (!p) begin
            n_t++; n_b++;
            if (tk)  ticks++;
            if (btk) bsteps++;
        end
        pwm++;
        led_exp = nxt;
        @(negedge clk_in);
    endtask

    initial begin
        int guard;
        logic p;
        model_reset();
        repeat (3) @(negedge clk_in);
        #1;
        chk("rst_mode", 32'(mode), 0);
        chk("rst_tick", 32'(tick), 0);
        chk("rst_leds", 32'({led_r, led_g, led_b}), 0);
        @(negedge clk_in);
        rst_n = 1'b1;

        // BLINK, then reset asynchronously while the LEDs are lit
        step(1'b1, 1'b0);
        repeat (20) step(1'b0, 1'b0);
        guard = 0;
        while (led_exp != 3'b111 && guard < 20) begin
            step(1'b0, 1'b0);
            guard++;
        end
        chk("blink_lit", 32'(led_exp), 32'h7);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_mode", 32'(mode), 0);
        chk("arst_leds", 32'({led_r, led_g, led_b}), 0);
        chk("arst_tick", 32'(tick), 0);
        model_reset();
        @(negedge clk_in);
        rst_n = 1'b1;
        repeat (4) begin
            step(1'b1, 1'b0);
            step(1'b0, 1'b0);
        end
        chk("mode_wrap", 32'(mode), 0);

        // CYCLE through the full color wheel, then pause
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        repeat (40) step(1'b0, 1'b0);
        repeat (10) step(1'b0, 1'b1);
        repeat (6) step(1'b0, 1'b0);

        // Button coincident with a tick while in CYCLE
        guard = 0;
        while (n_t % TD != TD - 1 && guard < 8) begin
            step(1'b0, 1'b0);
            guard++;
        end
        chk("tick_align", 32'(tick), 1);
        step(1'b1, 1'b0);
        chk("to_breathe", 32'(mode), 3);

        // Two full breathe periods with a few pauses sprinkled in
        repeat (70) step(1'b0, 1'b0);
        repeat (5) step(1'b0, 1'b1);
        repeat (70) step(1'b0, 1'b0);

        // Random stimulus
        p = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 19) == 0) p = ~p;
            step($urandom_range(0, 39) == 0, p);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
